// File: rtl/reg_bank_16_pkg.sv
// Shared widths and helpers for the 16-entry register bank.
package reg_bank_16_pkg;

    localparam int RB_WIDTH   = 16;
    localparam int RB_ENTRIES = 16;
    localparam int RB_ADDR_W  = 4;

    typedef logic [RB_ADDR_W-1:0]  rb_addr_t;
    typedef logic [RB_ENTRIES-1:0] rb_sel_t;

    // Saturating 8-bit increment: sticks at 8'hFF instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/reg_bank_16_onehot_check.sv
// Classifies the write select vector: all-zero, exactly one-hot, and the
// index of the set bit (meaningful only when one-hot).
module reg_bank_16_onehot_check
    import reg_bank_16_pkg::*;
(
    input  rb_sel_t  sel,
    output logic     is_zero,
    output logic     is_onehot,
    output rb_addr_t index
);

    localparam int CNT_W = $clog2(RB_ENTRIES + 1);

    logic [CNT_W-1:0] ones_s;

    // Population count and position of the highest set bit.
    always_comb begin
        ones_s = {CNT_W{1'b0}};
        index  = {RB_ADDR_W{1'b0}};
        for (int i = 0; i < RB_ENTRIES; i++) begin
            ones_s = ones_s + {{(CNT_W-1){1'b0}}, sel[i]};
            index  = sel[i] ? rb_addr_t'(i) : index;
        end
        is_zero   = (ones_s == {CNT_W{1'b0}});
        is_onehot = (ones_s == {{(CNT_W-1){1'b0}}, 1'b1});
    end

endmodule

// File: rtl/reg_bank_16.sv
// 16-entry register bank: one-hot strobed write port, two registered read
// ports with write-first bypass, sticky select-error flag and a saturating
// accepted-write counter.
module reg_bank_16
    import reg_bank_16_pkg::*;
#(
    parameter int WIDTH   = RB_WIDTH,
    parameter int ZERO_R0 = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_valid,
    input  rb_sel_t          wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  rb_addr_t         rd_addr_a,
    input  rb_addr_t         rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             rd_valid,
    output logic             sel_error,
    output logic [7:0]       wr_count
);

    localparam logic R0_HARD_ZERO = (ZERO_R0 != 0);

    logic             sel_zero_s;
    logic             sel_onehot_s;
    rb_addr_t         sel_idx_s;
    logic             wr_accept_s;
    logic             wr_store_s;
    logic             sel_bad_s;
    logic             byp_a_s;
    logic             byp_b_s;

    logic [WIDTH-1:0] mem_r [RB_ENTRIES];
    logic [WIDTH-1:0] rd_data_a_r;
    logic [WIDTH-1:0] rd_data_b_r;
    logic             rd_valid_r;
    logic             sel_error_r;
    logic [7:0]       wr_count_r;

    reg_bank_16_onehot_check u_onehot_check (
        .sel       (wr_sel),
        .is_zero   (sel_zero_s),
        .is_onehot (sel_onehot_s),
        .index     (sel_idx_s)
    );

    // Write qualification: accepted writes count even when entry 0 discards them.
    always_comb begin
        wr_accept_s = 1'b0;
        wr_store_s  = 1'b0;
        sel_bad_s   = 1'b0;
        if (wr_valid) begin
            wr_accept_s = sel_onehot_s;
            sel_bad_s   = ~sel_zero_s & ~sel_onehot_s;
            if (R0_HARD_ZERO && (sel_idx_s == {RB_ADDR_W{1'b0}})) begin
                wr_store_s = 1'b0;
            end else begin
                wr_store_s = sel_onehot_s;
            end
        end else begin
            wr_accept_s = 1'b0;
            wr_store_s  = 1'b0;
            sel_bad_s   = 1'b0;
        end
    end

    // Write-first bypass: a read of the entry being stored returns wr_data.
    always_comb begin
        byp_a_s = wr_store_s && (sel_idx_s == rd_addr_a);
        byp_b_s = wr_store_s && (sel_idx_s == rd_addr_b);
    end

    // Storage array update.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < RB_ENTRIES; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_store_s) begin
            mem_r[sel_idx_s] <= wr_data;
        end
    end

    // Registered read ports; data holds while rd_en is low.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_a_r <= {WIDTH{1'b0}};
            rd_data_b_r <= {WIDTH{1'b0}};
            rd_valid_r  <= 1'b0;
        end else begin
            rd_valid_r <= rd_en;
            if (rd_en) begin
                rd_data_a_r <= byp_a_s ? wr_data : mem_r[rd_addr_a];
                rd_data_b_r <= byp_b_s ? wr_data : mem_r[rd_addr_b];
            end
        end
    end

    // Sticky select error and saturating accepted-write count.
    always_ff @(posedge clock) begin
        if (reset) begin
            sel_error_r <= 1'b0;
            wr_count_r  <= 8'h00;
        end else begin
            if (sel_bad_s) begin
                sel_error_r <= 1'b1;
            end
            if (wr_accept_s) begin
                wr_count_r <= sat_inc8(wr_count_r);
            end
        end
    end

    assign rd_data_a = rd_data_a_r;
    assign rd_data_b = rd_data_b_r;
    assign rd_valid  = rd_valid_r;
    assign sel_error = sel_error_r;
    assign wr_count  = wr_count_r;

endmodule

// File: doc/reg_bank_16.md
REG_BANK_16 -- requirements
Module: reg_bank_16

Interface
REQ-001 Parameter: WIDTH, default 16 (from the shared width include), data width of each entry.
REQ-002 Parameter: ZERO_R0, default 1, when 1 entry 0 reads as zero and ignores writes.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_valid  input  1  write strobe; qualifies wr_sel, which the upstream demux holds between decodes.
REQ-006 wr_sel  input  16  one-hot write select; bit n = upstream out_n (bit 15 = out_F).
REQ-007 wr_data  input  WIDTH  write data.
REQ-008 rd_en  input  1  read request for both ports.
REQ-009 rd_addr_a, rd_addr_b  input  4 each  read addresses.
REQ-010 rd_data_a, rd_data_b  output  WIDTH each  registered read data.
REQ-011 rd_valid  output  1  one-cycle pulse marking new rd_data.
REQ-012 sel_error  output  1  sticky flag: strobed write with non-one-hot select.
REQ-013 wr_count  output  8  saturating count of accepted writes.

Function
REQ-014 Accepted write = wr_valid high and wr_sel exactly one-hot; entry n takes wr_data at that edge.
REQ-015 wr_valid high, wr_sel all zero: no write, no error, wr_count unchanged.
REQ-016 wr_valid high, two or more wr_sel bits set: no entry changes; sel_error set next cycle, held until reset.
REQ-017 wr_valid low: wr_sel and wr_data ignored whatever their value.
REQ-018 ZERO_R0=1 and wr_sel=16'h0001: write discarded, counted as accepted, no error; entry 0 always reads 0.
REQ-019 Read latency 1: rd_en high at edge k gives rd_data_a/b = entry[rd_addr_a/b] after edge k, rd_valid high for exactly the cycle after k.
REQ-020 Write-first bypass: read and accepted write to the same entry at the same edge return the new wr_data (except entry 0 with ZERO_R0=1).
REQ-021 Both read ports may address the same entry; both return identical data.
REQ-022 rd_en low: rd_data_a/b hold last values; rd_valid low.
REQ-023 wr_count increments by 1 per accepted write and saturates at 8'hFF; no wrap.
REQ-024 Back-to-back writes to any entries, one per cycle, with no stall; no ready signal exists.

Reset
REQ-025 Reset high at an edge: all 16 entries, rd_data_a/b, rd_valid, sel_error, wr_count go to 0.
REQ-026 Reset takes priority: a write or read in a reset cycle is discarded; no rd_valid pulse follows it.
REQ-027 First write or read is honoured at the first edge with reset low.

Structure
REQ-028 WIDTH default and the 16-entry count belong in the shared width/definition include; no local redefinition.
REQ-029 One sub-module is natural: onehot_check (16-bit in, outputs is_zero, is_onehot, 4-bit index); storage and read logic stay in reg_bank_16.
REQ-030 Storage is one 16 x WIDTH register array; no latches; all sequential logic in clocked blocks with synchronous reset.

Verification
REQ-031 Reset, then read all 16 entries -> every rd_data 0, rd_valid one cycle per read, wr_count 0.
REQ-032 Write 16'hA5A5 with wr_sel=16'h0020, then read addr 5 on both ports -> both 16'hA5A5 one cycle later; wr_count 1.
REQ-033 Same edge: write 16'h1234 to sel 16'h0100 and rd_en with rd_addr_a=8 -> rd_data_a 16'h1234 (bypass).
REQ-034 wr_valid with wr_sel=16'h0003 -> no entry changes, sel_error 1 next cycle and held; wr_sel=16'h0000 -> no error, no count.
REQ-035 Write 16'hFFFF to sel 16'h0001, read addr 0 -> 0; then 300 accepted writes -> wr_count 8'hFF.
REQ-036 Reset asserted in the same cycle as a write to entry 3 -> entry 3 reads 0 afterwards; sel_error and wr_count 0.
